// File: rtl/datapath_sequencer_if.sv
// Control/program/status bundle between the sequencer and whatever drives and observes it.
interface datapath_sequencer_if #(
  parameter int CW_WIDTH = 13,
  parameter int K_WIDTH  = 4,
  parameter int AW       = 4
);
  logic                        start;
  logic                        hold;
  logic                        prog_we;
  logic [AW-1:0]               prog_addr;
  logic [K_WIDTH+CW_WIDTH:0]   prog_data;
  logic [CW_WIDTH-1:0]         ControlWord;
  logic [K_WIDTH-1:0]          ConstantIn;
  logic                        busy;
  logic                        done;
  logic [AW-1:0]               pc;

  modport master (
    output start, hold, prog_we, prog_addr, prog_data,
    input  ControlWord, ConstantIn, busy, done, pc
  );

  modport slave (
    input  start, hold, prog_we, prog_addr, prog_data,
    output ControlWord, ConstantIn, busy, done, pc
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Microprogram sequencer: plays {last, constant, control word} entries to the datapath one per clock.
// Registered outputs, 1-cycle start latency; hold emits NOP, drops the stalled entry, then freezes pc.
module datapath_sequencer #(
  parameter int CW_WIDTH = 13,
  parameter int K_WIDTH  = 4,
  parameter int AW       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  datapath_sequencer_if.slave  bus
);
  localparam int DW    = 1 + K_WIDTH + CW_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DW-1:0]       r_mem [DEPTH];
  state_t              r_state;
  logic [CW_WIDTH-1:0] r_cw;
  logic [K_WIDTH-1:0]  r_k;
  logic                r_last;
  logic                r_held;
  logic                r_busy;
  logic                r_done;
  logic [AW-1:0]       r_pc;

  logic [DW-1:0]       w_entry;
  logic [DW-1:0]       w_entry0;
  logic                w_end;

  assign w_entry  = r_mem[r_pc];
  assign w_entry0 = r_mem[0];
  // pc back at 0 while running means address 15 was the last one emitted
  assign w_end    = r_last || (r_pc == '0);

  always_ff @(posedge clk) begin
    if (bus.prog_we && (r_state == S_IDLE)) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cw    <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_held  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cw   <= '0;
          r_k    <= '0;
          r_done <= 1'b0;
          r_held <= 1'b0;
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cw    <= w_entry0[CW_WIDTH-1:0];
            r_k     <= w_entry0[CW_WIDTH +: K_WIDTH];
            r_last  <= w_entry0[DW-1];
            r_pc    <= AW'(1);
          end
        end
        S_RUN: begin
          if (bus.hold) begin
            r_cw   <= '0;
            r_k    <= '0;
            r_held <= 1'b1;
            // First stalled cycle consumes the entry it replaces; later ones just freeze
            if (!r_held && !w_end) begin
              r_last <= w_entry[DW-1];
              r_pc   <= r_pc + 1'b1;
            end
          end else begin
            r_held <= 1'b0;
            if (w_end) begin
              r_cw    <= '0;
              r_k     <= '0;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cw   <= w_entry[CW_WIDTH-1:0];
              r_k    <= w_entry[CW_WIDTH +: K_WIDTH];
              r_last <= w_entry[DW-1];
              r_pc   <= r_pc + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_cw    <= '0;
          r_k     <= '0;
          r_done  <= 1'b0;
          r_pc    <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cw    <= '0;
          r_k     <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pc    <= '0;
        end
      endcase
    end
  end

  assign bus.ControlWord = r_cw;
  assign bus.ConstantIn  = r_k;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pc          = r_pc;
endmodule
